// File: rtl/gate_pkg.sv
// gate_pkg: op encoding and width-generic bitwise evaluator for gate_pipe
package gate_pkg;
  typedef enum logic [2:0] {
    OP_NOT, OP_BUF, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR
  } gate_op_e;
  // Widest operand gate_eval handles; callers zero-extend and take the low WIDTH bits.
  localparam int GATE_MAX_W = 256;
  function automatic logic [GATE_MAX_W-1:0] gate_eval(
    input gate_op_e                op,
    input logic [GATE_MAX_W-1:0]   a,
    input logic [GATE_MAX_W-1:0]   b
  );
    logic [GATE_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_NOT:  r = ~a;
      OP_BUF:  r = a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: one valid/ready register slice that loads whenever it can pass data on
//   clk, rst_n            clock, async active-low reset
//   valid_i/ready_o/data_i upstream side
//   valid_o/ready_i/data_o downstream side
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  logic         r_valid;
  logic [W-1:0] r_data;
  assign ready_o = ~r_valid | ready_i;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ready_o) begin
      r_valid <= valid_i;
      if (valid_i) r_data <= data_i;
    end
  end
endmodule

// File: rtl/gate_pipe.sv
// gate_pipe: pipelined WIDTH-bit 8-function logic unit with valid/ready, zero flag and transfer counter
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake; op, a, b sampled on accept
//   out_valid/out_ready        output handshake; y result, zero = (y == 0)
//   count                      wrapping count of output transfers
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  gate_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [CNT_W-1:0] count
);
  gate_op_e         w_op;
  logic [WIDTH-1:0] w_a, w_b, w_y;
  logic             w_v, w_rdy;
  logic [CNT_W-1:0] r_count;
  if (WIDTH > GATE_MAX_W) begin : g_wide
    $error("gate_pipe: WIDTH exceeds GATE_MAX_W");
  end
  // Operand source for the function: a registered stage, or the inputs directly.
  if (STAGES == 2) begin : g_two
    localparam int SW = 3 + 2 * WIDTH;
    logic [SW-1:0] w_s1;
    pipe_reg #(.W(SW)) u_s1 (
      .clk(clk), .rst_n(rst_n),
      .valid_i(in_valid), .ready_o(in_ready), .data_i({op, a, b}),
      .valid_o(w_v), .ready_i(w_rdy), .data_o(w_s1)
    );
    assign w_op = gate_op_e'(w_s1[SW-1 -: 3]);
    assign w_a  = w_s1[2*WIDTH-1:WIDTH];
    assign w_b  = w_s1[WIDTH-1:0];
  end else if (STAGES == 1) begin : g_one
    assign w_v      = in_valid;
    assign in_ready = w_rdy;
    assign w_op     = op;
    assign w_a      = a;
    assign w_b      = b;
  end else begin : g_bad
    $error("gate_pipe: STAGES must be 1 or 2");
  end
  assign w_y = WIDTH'(gate_eval(w_op, GATE_MAX_W'(w_a), GATE_MAX_W'(w_b)));
  pipe_reg #(.W(WIDTH + 1)) u_out (
    .clk(clk), .rst_n(rst_n),
    .valid_i(w_v), .ready_o(w_rdy), .data_i({w_y, ~|w_y}),
    .valid_o(out_valid), .ready_i(out_ready), .data_o({y, zero})
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (out_valid && out_ready) r_count <= r_count + 1'b1;
  end
  assign count = r_count;
endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: directed vector bench for gate_pipe (2-stage, 1-stage and 4-bit-counter instances)
module tb_gate_pipe;
  import gate_pkg::*;
  typedef struct {
    gate_op_e   op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  gate_op_e op = OP_NOT;
  logic [7:0] a = '0, b = '0;
  logic m_ir, m_ov, m_z, s_ir, s_ov, s_z, c_ir, c_ov, c_z;
  logic [7:0] m_y, s_y, c_y;
  logic [15:0] m_cnt, s_cnt;
  logic [3:0] c_cnt;
  int n_cmp = 0, n_err = 0;
  vec_t tab[10];
  always #5 clk = ~clk;
  gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_ir), .op(op), .a(a), .b(b),
    .out_valid(m_ov), .out_ready(out_ready), .y(m_y), .zero(m_z), .count(m_cnt));
  gate_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir), .op(op), .a(a), .b(b),
    .out_valid(s_ov), .out_ready(out_ready), .y(s_y), .zero(s_z), .count(s_cnt));
  gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ir), .op(op), .a(a), .b(b),
    .out_valid(c_ov), .out_ready(out_ready), .y(c_y), .zero(c_z), .count(c_cnt));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input vec_t v);
    in_valid = 1'b1;
    op = v.op;
    a = v.a;
    b = v.b;
  endtask
  task automatic do_reset;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov", 32'(m_ov), 0);
    chk("rst_y", 32'(m_y), 0);
    chk("rst_z", 32'(m_z), 0);
    chk("rst_cnt", 32'(m_cnt), 0);
    tick;
    tick;
    rst_n = 1'b1;
    chk("rst_ir", 32'(m_ir), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int ni, no, nx;
    logic acc, xf;
    tab[0] = '{OP_NOT,  8'hF0, 8'hCC, 8'h0F, 1'b0};
    tab[1] = '{OP_BUF,  8'hF0, 8'hCC, 8'hF0, 1'b0};
    tab[2] = '{OP_AND,  8'hF0, 8'hCC, 8'hC0, 1'b0};
    tab[3] = '{OP_OR,   8'hF0, 8'hCC, 8'hFC, 1'b0};
    tab[4] = '{OP_XOR,  8'hF0, 8'hCC, 8'h3C, 1'b0};
    tab[5] = '{OP_NAND, 8'hF0, 8'hCC, 8'h3F, 1'b0};
    tab[6] = '{OP_NOR,  8'hF0, 8'hCC, 8'h03, 1'b0};
    tab[7] = '{OP_XNOR, 8'hF0, 8'hCC, 8'hC3, 1'b0};
    tab[8] = '{OP_AND,  8'h0F, 8'hF0, 8'h00, 1'b1};
    tab[9] = '{OP_XNOR, 8'h55, 8'h55, 8'hFF, 1'b0};
    // basic NOT
    do_reset;
    out_ready = 1'b1;
    apply('{OP_NOT, 8'hA5, 8'h00, 8'h5A, 1'b0});
    tick;
    in_valid = 1'b0;
    chk("basic_ov_early", 32'(m_ov), 0);
    tick;
    chk("basic_ov", 32'(m_ov), 1);
    chk("basic_y", 32'(m_y), 32'h5A);
    chk("basic_z", 32'(m_z), 0);
    tick;
    chk("basic_cnt", 32'(m_cnt), 1);
    chk("basic_ov_done", 32'(m_ov), 0);
    // back-to-back table stream: 2-stage shows vector j-2, 1-stage shows j-1
    do_reset;
    out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j < 10) apply(tab[j]);
      else in_valid = 1'b0;
      chk("tab_ir", 32'(m_ir), 1);
      if (j >= 2) begin
        chk("tab_ov", 32'(m_ov), 1);
        chk("tab_y", 32'(m_y), 32'(tab[j-2].y));
        chk("tab_z", 32'(m_z), 32'(tab[j-2].z));
      end
      if (j >= 1 && j <= 10) begin
        chk("s1_ov", 32'(s_ov), 1);
        chk("s1_y", 32'(s_y), 32'(tab[j-1].y));
        chk("s1_z", 32'(s_z), 32'(tab[j-1].z));
      end
      tick;
    end
    chk("tab_cnt", 32'(m_cnt), 10);
    chk("s1_cnt", 32'(s_cnt), 10);
    chk("tab_ov_end", 32'(m_ov), 0);
    // dedicated 1-stage latency
    do_reset;
    out_ready = 1'b1;
    apply(tab[9]);
    tick;
    in_valid = 1'b0;
    chk("s1x_ov", 32'(s_ov), 1);
    chk("s1x_y", 32'(s_y), 32'hFF);
    chk("s1x_main_ov", 32'(m_ov), 0);
    // backpressure: out_ready low for cycles 0..6
    do_reset;
    ni = 0;
    no = 0;
    for (int c = 0; c < 20 && no < 4; c++) begin
      out_ready = (c >= 7);
      in_valid = (ni < 4);
      if (ni < 4) apply(tab[4+ni]);
      #1;
      if (c >= 2 && c <= 6) begin
        chk("bp_ir", 32'(m_ir), 0);
        chk("bp_ov", 32'(m_ov), 1);
        chk("bp_hold_y", 32'(m_y), 32'(tab[4].y));
      end
      if (c == 7) chk("bp_ir_rise", 32'(m_ir), 1);
      acc = in_valid && m_ir;
      xf = m_ov && out_ready;
      if (xf) begin
        chk("bp_order", 32'(m_y), 32'(tab[4+no].y));
        no++;
      end
      tick;
      if (acc) ni++;
    end
    chk("bp_n", 32'(no), 4);
    chk("bp_cnt", 32'(m_cnt), 4);
    chk("bp_ov_end", 32'(m_ov), 0);
    // 4-bit counter wrap
    do_reset;
    out_ready = 1'b1;
    ni = 0;
    nx = 0;
    for (int c = 0; c < 40 && nx < 17; c++) begin
      in_valid = (ni < 17);
      op = OP_BUF;
      a = 8'(ni);
      b = 8'h00;
      #1;
      acc = in_valid && c_ir;
      xf = c_ov && out_ready;
      tick;
      if (acc) ni++;
      if (xf) begin
        nx++;
        if (nx >= 15) chk("wrap_cnt", 32'(c_cnt), 32'(nx % 16));
      end
    end
    chk("wrap_n", 32'(nx), 17);
    // reset mid-flight
    do_reset;
    apply('{OP_XOR, 8'h12, 8'h34, 8'h26, 1'b0});
    tick;
    apply('{OP_BUF, 8'h77, 8'h00, 8'h77, 1'b0});
    tick;
    in_valid = 1'b0;
    chk("mf_ov", 32'(m_ov), 1);
    chk("mf_y0", 32'(m_y), 32'h26);
    out_ready = 1'b1;
    tick;
    chk("mf_cnt", 32'(m_cnt), 1);
    chk("mf_y1", 32'(m_y), 32'h77);
    do_reset;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("mf_no_stale", 32'(m_ov), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
